// File: rtl/ov7670_init_sequencer.sv
// OV7670 register-table walker: reads {reg,value} entries from a synchronous ROM
// and issues one SCCB 3-phase write per entry, honouring end/delay markers.
module ov7670_init_sequencer #(
  parameter logic [7:0]  DEVICE_ID      = 8'h42,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned POWERUP_CYCLES = 1000000,
  parameter int unsigned DELAY_CYCLES   = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic [7:0]        sccb_id,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_busy,
  input  logic              sccb_done,
  output logic              busy,
  output logic              init_done,
  output logic              error,
  output logic [ADDR_W:0]   write_count
);

  localparam int unsigned MAX_PD  = (POWERUP_CYCLES > DELAY_CYCLES) ? POWERUP_CYCLES : DELAY_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_PD > TIMEOUT_CYCLES) ? MAX_PD : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_POWERUP,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] rom_addr_nxt;
  logic [ADDR_W:0]   write_count_nxt;
  logic [7:0]        sccb_addr_nxt, sccb_wdata_nxt;
  logic              start_seq, advance;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      rom_addr    <= '0;
      write_count <= '0;
      sccb_addr   <= '0;
      sccb_wdata  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rom_addr    <= rom_addr_nxt;
      write_count <= write_count_nxt;
      sccb_addr   <= sccb_addr_nxt;
      sccb_wdata  <= sccb_wdata_nxt;
    end
  end

  // The counter is loaded with 1 when a delay or write begins, so the decode
  // cycle (delay) and the start cycle (timeout) count toward the wait length.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rom_addr_nxt    = rom_addr;
    write_count_nxt = write_count;
    sccb_addr_nxt   = sccb_addr;
    sccb_wdata_nxt  = sccb_wdata;
    sccb_start      = 1'b0;
    start_seq       = 1'b0;
    advance         = 1'b0;

    case (state)
      S_IDLE: begin
        if (AUTO_START || go) start_seq = 1'b1;
      end
      S_POWERUP: begin
        if (cnt >= PWR_LAST) state_nxt = S_FETCH;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (rom_data == 16'hFFFF) begin
          state_nxt = S_DONE;
        end else if (rom_data == 16'hFFF0) begin
          state_nxt = S_DELAY;
          cnt_nxt   = CNT_W'(1);
        end else begin
          sccb_addr_nxt  = rom_data[15:8];
          sccb_wdata_nxt = rom_data[7:0];
          state_nxt      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!sccb_busy) begin
          sccb_start = 1'b1;
          cnt_nxt    = CNT_W'(1);
          state_nxt  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (sccb_done) begin
          write_count_nxt = write_count + 1'b1;
          advance         = 1'b1;
        end else if (cnt >= TMO_LAST) begin
          state_nxt = S_ERROR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DELAY: begin
        if (cnt >= DLY_LAST) advance = 1'b1;
        else                 cnt_nxt = cnt + 1'b1;
      end
      S_DONE, S_ERROR: begin
        if (go) start_seq = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (start_seq) begin
      state_nxt       = S_POWERUP;
      rom_addr_nxt    = '0;
      write_count_nxt = '0;
      cnt_nxt         = '0;
    end

    if (advance) begin
      if (rom_addr == '1) begin
        state_nxt = S_DONE;
      end else begin
        rom_addr_nxt = rom_addr + 1'b1;
        state_nxt    = S_FETCH;
      end
    end
  end

  assign sccb_id   = DEVICE_ID;
  assign busy      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  assign init_done = (state == S_DONE);
  assign error     = (state == S_ERROR);

endmodule

// File: tb/tb_ov7670_init_sequencer.sv
// Bench for ov7670_init_sequencer: a schedule model predicts every start, hold,
// count and status cycle from the table; directed scenarios pin key latencies.
module tb_ov7670_init_sequencer;

  logic        clock = 1'b0;
  logic        rst_a, rst_b, go_a, go_b;
  logic [3:0]  rom_addr, rom_addr_b;
  logic [15:0] rom_data, rom_data_b;
  logic        sccb_start, sccb_start_b;
  logic [7:0]  sccb_id, sccb_addr, sccb_wdata, sccb_id_b, sccb_addr_b, sccb_wdata_b;
  logic        sccb_busy, sccb_done;
  logic        busy, init_done, error, busy_b, init_done_b, error_b;
  logic [4:0]  write_count, write_count_b;

  always #5 clock = ~clock;

  ov7670_init_sequencer #(
    .DEVICE_ID(8'h42), .ADDR_W(4), .POWERUP_CYCLES(10), .DELAY_CYCLES(20),
    .TIMEOUT_CYCLES(100), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset(rst_a), .go(go_a), .rom_addr(rom_addr), .rom_data(rom_data),
    .sccb_start(sccb_start), .sccb_id(sccb_id), .sccb_addr(sccb_addr),
    .sccb_wdata(sccb_wdata), .sccb_busy(sccb_busy), .sccb_done(sccb_done),
    .busy(busy), .init_done(init_done), .error(error), .write_count(write_count)
  );

  assign rom_data_b = 16'hFFFF;

  ov7670_init_sequencer #(
    .DEVICE_ID(8'h42), .ADDR_W(4), .POWERUP_CYCLES(10), .DELAY_CYCLES(20),
    .TIMEOUT_CYCLES(100), .AUTO_START(1'b0)
  ) dut_b (
    .clock(clock), .reset(rst_b), .go(go_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .sccb_start(sccb_start_b), .sccb_id(sccb_id_b), .sccb_addr(sccb_addr_b),
    .sccb_wdata(sccb_wdata_b), .sccb_busy(1'b0), .sccb_done(1'b0),
    .busy(busy_b), .init_done(init_done_b), .error(error_b), .write_count(write_count_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scenario table and synchronous ROM
  logic [15:0] rom [16];
  always @(posedge clock) rom_data <= rom[rom_addr];

  // Core model: done 8 cycles after start; optional busy burst after a given done
  int busy_after  = 0;
  int no_done_idx = -1;
  int c_target, c_nstart, c_ndone, c_b0, c_b1;

  always @(negedge clock) begin
    if (!rst_a) begin
      c_target = -1; c_nstart = 0; c_ndone = 0; c_b0 = -1; c_b1 = -2;
    end else begin
      if (sccb_start) begin
        if (c_nstart != no_done_idx) c_target = cyc + 8;
        c_nstart++;
      end
      if (sccb_done) begin
        c_ndone++;
        if (c_ndone == busy_after) begin c_b0 = cyc + 1; c_b1 = cyc + 15; end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    sccb_done = (cyc == c_target);
    sccb_busy = (cyc >= c_b0) && (cyc <= c_b1);
  end

  // Schedule model
  int m_T, m_end, m_nstart, m_ndone, m_naddr, k_next;
  bit m_err;
  int m_start_cyc [32];
  int m_hold_end  [32];
  int m_reg       [32];
  int m_val       [32];
  int m_done_cyc  [32];
  int m_addr_cyc  [17];
  bit chk_en = 1'b0;
  int act_start [$];

  task automatic build_model(input int trig);
    int t, a, s, d, b0, b1;
    bit fin;
    m_T = trig; m_nstart = 0; m_ndone = 0; m_naddr = 1; m_addr_cyc[0] = trig;
    k_next = 0; b0 = -1; b1 = -2; d = 0;
    t = trig + 10; a = 0; fin = 1'b0;
    while (!fin) begin
      if (rom[a] == 16'hFFFF) begin
        m_end = t + 2; m_err = 1'b0; fin = 1'b1;
      end else begin
        if (rom[a] == 16'hFFF0) begin
          d = t + 20;
        end else begin
          s = t + 2;
          if (s >= b0 && s <= b1) s = b1 + 1;
          m_start_cyc[m_nstart] = s;
          m_reg[m_nstart] = int'(rom[a][15:8]);
          m_val[m_nstart] = int'(rom[a][7:0]);
          if (m_nstart == no_done_idx) begin
            m_hold_end[m_nstart] = s + 100;
            m_end = s + 100; m_err = 1'b1; fin = 1'b1;
          end else begin
            d = s + 8;
            m_hold_end[m_nstart] = d;
            m_done_cyc[m_ndone] = d;
            m_ndone++;
            if (m_ndone == busy_after) begin b0 = d + 1; b1 = d + 15; end
          end
          m_nstart++;
        end
        if (!fin) begin
          if (a == 15) begin
            m_end = d + 1; m_err = 1'b0; fin = 1'b1;
          end else begin
            a++; t = d + 1;
            m_addr_cyc[m_naddr] = t; m_naddr++;
          end
        end
      end
    end
  endtask

  always @(negedge clock) begin
    int c, wc, ra;
    bit es;
    if (chk_en && cyc >= m_T && cyc <= m_end + 4) begin
      c = cyc;
      chk("sccb_id", sccb_id, 8'h42);
      es = (k_next < m_nstart) && (m_start_cyc[k_next] == c);
      chk("sccb_start", sccb_start, es);
      if (sccb_start) act_start.push_back(c);
      if (es) begin
        chk("start_addr", sccb_addr, m_reg[k_next]);
        chk("start_data", sccb_wdata, m_val[k_next]);
        k_next++;
      end else if (k_next > 0 && c <= m_hold_end[k_next-1]) begin
        chk("hold_addr", sccb_addr, m_reg[k_next-1]);
        chk("hold_data", sccb_wdata, m_val[k_next-1]);
      end
      wc = 0;
      for (int i = 0; i < m_ndone; i++) if (m_done_cyc[i] < c) wc++;
      ra = 0;
      for (int i = 0; i < m_naddr; i++) if (m_addr_cyc[i] <= c) ra = i;
      chk("write_count", write_count, wc);
      chk("rom_addr", rom_addr, ra);
      chk("busy", busy, c < m_end);
      chk("init_done", init_done, (c >= m_end) && !m_err);
      chk("error", error, (c >= m_end) && m_err);
    end
  end

  task automatic load(input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [15:0] e3);
    for (int i = 0; i < 16; i++) rom[i] = 16'hFFFF;
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  task automatic run_auto();
    @(negedge clock);
    chk_en = 1'b0;
    rst_a = 1'b0;
    repeat (2) @(negedge clock);
    act_start.delete();
    build_model(cyc + 1);
    chk_en = 1'b1;
    rst_a = 1'b1;
  endtask

  task automatic wait_end();
    while (cyc <= m_end + 5) @(negedge clock);
    chk_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, starts;
    rst_a = 1'b0; rst_b = 1'b0; go_a = 1'b0; go_b = 1'b0;
    sccb_busy = 1'b0; sccb_done = 1'b0;
    load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clock);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", sccb_start, 0);
    chk("rst_id", sccb_id, 8'h42);
    chk("rst_wcount", write_count, 0);
    chk("rst_addr", sccb_addr, 0);
    chk("rst_done", init_done, 0);
    chk("rst_error", error, 0);

    // 1: nominal
    load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    busy_after = 0; no_done_idx = -1;
    run_auto();
    wait_end();
    chk("t1_nstarts", act_start.size(), 2);
    if (act_start.size() >= 1) chk("t1_first_start_lat", act_start[0] - m_T, 12);
    chk("t1_init_done", init_done, 1);
    chk("t1_wcount", write_count, 2);

    // 2: delay marker
    load(16'h1280, 16'hFFF0, 16'h3A04, 16'hFFFF);
    run_auto();
    wait_end();
    chk("t2_nstarts", act_start.size(), 2);
    if (act_start.size() >= 2) chk("t2_delay_gap", act_start[1] - (act_start[0] + 8), 24);
    chk("t2_wcount", write_count, 2);

    // 3: busy hold at second issue
    load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    busy_after = 1;
    run_auto();
    wait_end();
    chk("t3_nstarts", act_start.size(), 2);
    if (act_start.size() >= 2) chk("t3_busy_gap", act_start[1] - (act_start[0] + 8), 16);
    busy_after = 0;

    // 4: timeout on entry 1, then restart with go
    load(16'h1280, 16'h1100, 16'h3A04, 16'hFFFF);
    no_done_idx = 1;
    run_auto();
    wait_end();
    chk("t4_timeout_len", m_end - m_start_cyc[1], 100);
    chk("t4_error", error, 1);
    chk("t4_rom_addr", rom_addr, 1);
    chk("t4_busy", busy, 0);
    no_done_idx = -1;
    act_start.delete();
    build_model(cyc + 1);
    chk_en = 1'b1;
    go_a = 1'b1;
    @(negedge clock);
    go_a = 1'b0;
    chk("t4_restart_addr", rom_addr, 0);
    chk("t4_restart_wcount", write_count, 0);
    wait_end();
    chk("t4_restart_done", init_done, 1);
    chk("t4_restart_wcount_end", write_count, 3);

    // 5: full table, no end marker
    for (int i = 0; i < 16; i++) rom[i] = {8'h10 + 8'(i), 8'hA0 + 8'(i)};
    run_auto();
    wait_end();
    chk("t5_wcount", write_count, 16);
    chk("t5_rom_addr", rom_addr, 15);
    chk("t5_init_done", init_done, 1);

    // 6: reset during WAIT_DONE of the second write
    load(16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF);
    run_auto();
    for (int i = 0; i < 200 && act_start.size() < 2; i++) @(negedge clock);
    chk("t6_reached_write2", act_start.size(), 2);
    repeat (3) @(negedge clock);
    chk_en = 1'b0;
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_rom_addr", rom_addr, 1);
    chk("t6_pre_wcount", write_count, 1);
    #2 rst_a = 1'b0;
    #1;
    chk("t6_rst_rom_addr", rom_addr, 0);
    chk("t6_rst_wcount", write_count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", sccb_addr, 0);
    chk("t6_rst_data", sccb_wdata, 0);
    chk("t6_rst_id", sccb_id, 8'h42);
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (sccb_start) starts++;
    end
    chk("t6_no_start_in_reset", starts, 0);

    // 6b: AUTO_START=0 waits for go; go while busy is ignored
    rst_b = 1'b1;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (busy_b || sccb_start_b) starts++;
    end
    chk("t6b_idle_hold", starts, 0);
    go_b = 1'b1;
    g = cyc + 1;
    @(negedge clock);
    go_b = 1'b0;
    chk("t6b_busy_after_go", busy_b, 1);
    repeat (3) @(negedge clock);
    go_b = 1'b1;
    @(negedge clock);
    go_b = 1'b0;
    while (cyc < g + 11) @(negedge clock);
    chk("t6b_not_done_yet", init_done_b, 0);
    chk("t6b_busy_before_done", busy_b, 1);
    @(negedge clock);
    chk("t6b_done_at_12", init_done_b, 1);
    chk("t6b_idle_at_done", busy_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ov7670_init_sequencer.md
Name: ov7670_init_sequencer

Overview:
Register-initialisation controller for the OV7670 camera's SCCB write path. It walks a table of 16-bit {register, value} entries in an external synchronous ROM and issues one 3-phase SCCB write per entry to the sccb core. The core returns a done pulse per write. The table may contain end and delay markers. Sits between the top-level camera bring-up logic and the sccb core.

Parameters:
DEVICE_ID, 8'h42, SCCB write ID sent as phase 1 of every transaction
ADDR_W, 8, ROM address width; table holds at most 2**ADDR_W entries
POWERUP_CYCLES, 1000000, wait after start before the first write (camera settle)
DELAY_CYCLES, 1000000, wait length for a delay-marker entry
TIMEOUT_CYCLES, 65535, maximum cycles from sccb_start to sccb_done
AUTO_START, 1, 1 = sequence starts automatically on reset release; 0 = waits for go

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
go  in  1  level/pulse; starts or restarts the sequence from IDLE, DONE or ERROR
rom_addr  out  ADDR_W  table address
rom_data  in  16  {reg[15:8], value[7:0]}; valid 1 cycle after rom_addr
sccb_start  out  1  1-cycle request to the sccb core
sccb_id  out  8  phase-1 byte; always DEVICE_ID
sccb_addr  out  8  phase-2 register address; held stable from sccb_start until sccb_done
sccb_wdata  out  8  phase-3 data; held stable from sccb_start until sccb_done
sccb_busy  in  1  core busy; start is only issued when low
sccb_done  in  1  1-cycle pulse; current write complete
busy  out  1  high in every state except IDLE, DONE and ERROR
init_done  out  1  high in DONE
error  out  1  high in ERROR (timeout)
write_count  out  ADDR_W+1  number of completed writes since the last start

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE; all outputs 0, except sccb_id=DEVICE_ID.
  - All counters are cleared.
- Asserting reset mid-transaction aborts immediately; no further sccb_start is issued.
- IDLE:
  - Goes to POWERUP if AUTO_START=1 (first cycle after reset release) or if go=1.
  - Entry to POWERUP clears rom_addr, write_count and the cycle counter.
- POWERUP: counts POWERUP_CYCLES cycles, then goes to FETCH.
- FETCH: rom_addr is already driven; wait exactly 1 cycle, then go to DECODE.
- DECODE samples rom_data:
  - 16'hFFFF (end marker) -> DONE.
  - 16'hFFF0 (delay marker) -> DELAY.
  - Any other value -> latch sccb_addr=rom_data[15:8] and sccb_wdata=rom_data[7:0], then go to ISSUE.
- ISSUE:
  - While sccb_busy=1, stay in ISSUE.
  - Otherwise pulse sccb_start for exactly 1 cycle, clear the timeout counter, and go to WAIT_DONE.
- WAIT_DONE:
  - On sccb_done: write_count+1, then ADVANCE.
  - If the timeout counter reaches TIMEOUT_CYCLES first: ERROR; rom_addr is frozen at the failing entry.
  - If sccb_done arrives in the same cycle the timeout expires, the done wins.
- DELAY: counts DELAY_CYCLES cycles, then ADVANCE. Delay markers do not increment write_count.
- ADVANCE (combined into the transition, no extra state):
  - If rom_addr == 2**ADDR_W-1: DONE (implicit end; no wrap to 0).
  - Otherwise rom_addr+1, then FETCH.
- DONE / ERROR:
  - Outputs are held.
  - go=1 restarts via POWERUP with all counters cleared.
- go is ignored while busy=1.
- sccb_done outside WAIT_DONE is ignored.
- Per-write overhead when the core is idle: FETCH 1 + DECODE 1 + ISSUE 1 cycle before sccb_start. Back-to-back entries therefore give sccb_start 3 cycles after the previous sccb_done, plus the core latency.
- Counters are sized with $clog2(max(POWERUP_CYCLES, DELAY_CYCLES, TIMEOUT_CYCLES)+1). The same counter register is shared across the states that use it.

Test Plan:
Bench parameters: POWERUP=10, DELAY=20, TIMEOUT=100, ADDR_W=4. The bench's core model asserts sccb_done 8 cycles after sccb_start.
1. Nominal sequence:
   - Stimulus: table {1280, 1100, FFFF}, AUTO_START=1.
   - Required: first sccb_start 12 cycles after reset release (10 POWERUP + FETCH + DECODE, start issued in ISSUE) with addr 12/data 80.
   - Then addr 11/data 00, then init_done=1, write_count=2, sccb_id=42 throughout.
2. Delay marker:
   - Stimulus: table {1280, FFF0, 3A04, FFFF}.
   - Required: gap from the 1st sccb_done to the 2nd sccb_start is 20+3+1 cycles.
   - write_count=2 at the end.
3. Busy hold:
   - Stimulus: hold sccb_busy=1 for 15 cycles at the 2nd ISSUE.
   - Required: no sccb_start while busy; start occurs 1 cycle after busy falls.
   - addr/data stay stable until done.
4. Timeout:
   - Stimulus: the core never returns done on entry 1.
   - Required: error=1 exactly 100 cycles after that sccb_start; rom_addr=1; busy=0.
   - Then go=1 restarts from rom_addr=0 with write_count=0.
5. Full table with no end marker:
   - Stimulus: 16 valid entries.
   - Required: DONE after entry 15 with write_count=16; rom_addr stays 15, no wrap.
6. Reset mid-WAIT_DONE:
   - Stimulus: assert reset.
   - Required: all outputs clear asynchronously.
   - With AUTO_START=0 the block stays IDLE until go; go pulses during busy have no effect.
